// File: rtl/des_pkg.sv
// Shared DES constants: S1..S8 substitution boxes, the P permutation and datapath widths.
// Each S-box is 64 nibbles, row-major (row 0 col 0 in the top nibble).
package des_pkg;

  localparam int unsigned DES_E_WIDTH = 48;
  localparam int unsigned DES_F_WIDTH = 32;

  localparam logic [255:0] DES_S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] DES_S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] DES_S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] DES_S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] DES_S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] DES_S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] DES_S7 = 256'h4B2EF08D3C975A61_D0B74910E35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] DES_S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  // Standard 1-based P table: output bit i takes substitution bit DES_P[i].
  localparam logic [5:0] DES_P [32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // rc = {row[1:0], col[3:0]}; box 0 selects S1.
  function automatic logic [3:0] des_sbox(input logic [2:0] box, input logic [5:0] rc);
    logic [255:0] tbl;
    case (box)
      3'd0:    tbl = DES_S1;
      3'd1:    tbl = DES_S2;
      3'd2:    tbl = DES_S3;
      3'd3:    tbl = DES_S4;
      3'd4:    tbl = DES_S5;
      3'd5:    tbl = DES_S6;
      3'd6:    tbl = DES_S7;
      default: tbl = DES_S8;
    endcase
    return tbl[8'd252 - {rc, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/des_sbox_lookup.sv
// Combinational DES S-box lookup; bits[0] is the first DES bit of the 6-bit group.
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] bits,
  output logic [3:0] val
);

  // Row is the outer bit pair, column the inner four bits.
  always_comb begin
    val = des_sbox(box, {bits[0], bits[5], bits[1], bits[2], bits[3], bits[4]});
  end

endmodule

// File: rtl/sbox_compress.sv
// DES f-block compression: eight S-box substitutions over a held 48-bit word,
// GROUPS_PER_CYCLE groups per clock, followed by the P permutation.
module sbox_compress
  import des_pkg::*;
#(
  parameter int unsigned GROUPS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DES_E_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DES_F_WIDTH-1:0] out_data
);

  localparam int unsigned GW = 3;
  localparam logic [GW-1:0] GSTEP = GW'(GROUPS_PER_CYCLE);
  localparam logic [GW-1:0] GLAST = GW'(8 - GROUPS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [GW-1:0]          grp;
  logic [DES_E_WIDTH-1:0] hold;
  logic [DES_F_WIDTH-1:0] s;
  logic [GW-1:0]          gidx [GROUPS_PER_CYCLE];
  logic [3:0]             gval [GROUPS_PER_CYCLE];

  // One lookup lane per group substituted in a cycle.
  for (genvar g = 0; g < GROUPS_PER_CYCLE; g++) begin : g_lane
    logic [5:0] base;
    assign gidx[g] = grp + GW'(g);
    assign base    = {3'b000, gidx[g]} * 6'd6;
    des_sbox_lookup u_lookup (
      .box  (gidx[g]),
      .bits (hold[base +: 6]),
      .val  (gval[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = SUB;
      SUB:     if (grp == GLAST) state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // s is never cleared between words: all 32 bits are rewritten during SUB.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp  <= '0;
      hold <= '0;
      s    <= '0;
    end else if (state == IDLE && in_valid) begin
      hold <= in_data;
      grp  <= '0;
    end else if (state == SUB) begin
      grp <= grp + GSTEP;
      for (int g = 0; g < int'(GROUPS_PER_CYCLE); g++) begin
        s[{gidx[g], 2'b00} +: 4] <= {gval[g][0], gval[g][1], gval[g][2], gval[g][3]};
      end
    end
  end

  for (genvar i = 0; i < DES_F_WIDTH; i++) begin : g_perm
    assign out_data[i] = s[5'(DES_P[i] - 6'd1)];
  end

endmodule

// File: tb/tb_sbox_compress.sv
// Directed bench for sbox_compress: one instance per legal GROUPS_PER_CYCLE, driven from one initial block.
module tb_sbox_compress;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [47:0] in_data  [4];
  logic [31:0] out_data [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sbox_compress #(.GROUPS_PER_CYCLE(32'd1 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  int pt [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] model(input logic [47:0] x);
    logic [31:0] sv;
    logic [31:0] o;
    int          row, col, v;
    for (int k = 0; k < 8; k++) begin
      row = 2 * int'(x[6*k]) + int'(x[6*k+5]);
      col = 8 * int'(x[6*k+1]) + 4 * int'(x[6*k+2]) + 2 * int'(x[6*k+3]) + int'(x[6*k+4]);
      v   = sb[k][16*row + col];
      for (int b = 0; b < 4; b++) sv[4*k+b] = v[3-b];
    end
    for (int i = 0; i < 32; i++) o[i] = sv[pt[i]-1];
    return o;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [47:0] x);
    int t = 0;
    in_data[d]  = x;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && t < 20) begin tick(); t++; end
    chk("send_in_ready", 32'(in_ready[d]), 32'd1);
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin tick(); lat++; end
    chk("out_valid_seen", 32'(out_valid[d]), 32'd1);
  endtask

  task automatic drain(input int d);
    chk("done_in_ready_low", 32'(in_ready[d]), 32'd0);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk("idle_in_ready", 32'(in_ready[d]), 32'd1);
    chk("idle_out_valid", 32'(out_valid[d]), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [47:0] din;
    logic [31:0] exp_des;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int          lat;
    int          prev_acc;
    int          t;
    logic        seen;
    logic [31:0] snap;
    logic [47:0] x;

    vecs[0] = '{"zero",   48'h0000_0000_0000, 32'hD8D8DBBC};
    vecs[1] = '{"s1_only", 48'h0000_0000_0036, 32'hD858D9BE};
    vecs[2] = '{"ones",   48'hFFFF_FFFF_FFFF, 32'h38DBF9CB};

    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < 4; d++) in_data[d] = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int d = 0; d < 4; d++) begin
      chk("reset_in_ready", 32'(in_ready[d]), 32'd1);
      chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset_out_data", out_data[d], 32'd0);
    end

    for (int v = 0; v < 3; v++) begin
      send(0, vecs[v].din);
      wait_done(0, lat);
      chk({vecs[v].name, "_latency"}, 32'(lat), 32'd8);
      chk({vecs[v].name, "_data"}, rev32(out_data[0]), vecs[v].exp_des);
      chk({vecs[v].name, "_model"}, out_data[0], model(vecs[v].din));
      drain(0);
    end

    for (int d = 1; d < 4; d++) begin
      send(d, 48'h0);
      wait_done(d, lat);
      chk("sweep_latency", 32'(lat), 32'(8 >> d));
      chk("sweep_data", rev32(out_data[d]), 32'hD8D8DBBC);
      drain(d);
    end

    // Held output under backpressure while the input side is toggled.
    send(0, 48'h0000_0000_0036);
    wait_done(0, lat);
    snap = out_data[0];
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = 1'(i % 2);
      in_data[0]  = 48'({$urandom(), $urandom()});
      tick();
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data", out_data[0], snap);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    chk("bp_data_value", rev32(snap), 32'hD858D9BE);
    drain(0);

    // Reset during SUB cycle 3 discards the word.
    send(0, 48'hFFFF_FFFF_FFFF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sub_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_sub_out_valid", 32'(out_valid[0]), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid[0]) seen = 1'b1;
    end
    chk("rst_sub_no_output", 32'(seen), 32'd0);
    send(0, 48'h0);
    wait_done(0, lat);
    chk("rst_sub_next_latency", 32'(lat), 32'd8);
    chk("rst_sub_next_data", rev32(out_data[0]), 32'hD8D8DBBC);
    drain(0);

    // Reset while DONE is waiting for the consumer.
    send(0, 48'hFFFF_FFFF_FFFF);
    wait_done(0, lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_done_out_data", out_data[0], 32'd0);
    chk("rst_done_in_ready", 32'(in_ready[0]), 32'd1);

    // Back-to-back streaming with both handshakes held high.
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    prev_acc     = 0;
    for (int w = 0; w < 16; w++) begin
      x = 48'({$urandom(), $urandom()});
      in_data[0] = x;
      t = 0;
      while (!in_ready[0] && t < 20) begin tick(); t++; end
      chk("b2b_in_ready", 32'(in_ready[0]), 32'd1);
      if (w > 0) chk("b2b_interval", 32'(cyc - prev_acc), 32'd10);
      prev_acc = cyc;
      tick();
      t = 0;
      while (!out_valid[0] && t < 40) begin tick(); t++; end
      chk("b2b_out_valid", 32'(out_valid[0]), 32'd1);
      chk("b2b_data", out_data[0], model(x));
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
